// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble controller for an in-order pipeline of STAGES stages.
// Latency: stall_o/bubble_o/flush_o decode combinationally in the request cycle;
//   flush_pend_o/stall_cnt_o/timeout_o are registered.
// Backpressure: rdy=0 holds every stage and freezes all state; a flush that would hit a
//   stalled stage is deferred and issues in the first rdy cycle where nothing at or above
//   its stage stalls.
// Ports:
//   clk, rst (async, active-high), rdy (global ready)
//   stall_req_i[k] : stage k cannot advance
//   flush_req_i[k] : stage k redirects, flushing stages 0..k-1 (bit 0 has no effect)
//   stall_o        : per-stage hold
//   bubble_o       : one-hot NOP load into the stage just after the highest stall
//   flush_o        : per-stage clear
//   flush_pend_o   : a deferred flush is held
//   stall_cnt_o    : saturating count of cycles with any stall
//   timeout_o      : sticky flag, TIMEOUT consecutive stalled cycles seen
module pipe_hazard_ctrl #(
  parameter int STAGES  = 6,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic [STAGES-1:0] flush_req_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] bubble_o,
  output logic [STAGES-1:0] flush_o,
  output logic              flush_pend_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              timeout_o
);

  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int RW = $clog2(TIMEOUT + 1);

  // Registered state
  logic          pend_vld_q, pend_vld_d;
  logic [IW-1:0] pend_idx_q, pend_idx_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          timeout_q, timeout_d;

  // Decode
  logic          s_vld, fl_vld, f_vld;
  logic [IW-1:0] s_idx, fl_idx, f_idx;
  logic [STAGES-1:0] stall_raw, bubble_raw, flush_raw;
  logic          issue, defer, stall_any;

  // Highest requesting stage for stall and flush.
  always_comb begin
    s_vld  = 1'b0;
    s_idx  = '0;
    fl_vld = 1'b0;
    fl_idx = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stall_req_i[k]) begin
        s_vld = 1'b1;
        s_idx = IW'(k);
      end
      // Stage 0 has nothing upstream to flush, so its request bit is ignored.
      if (flush_req_i[k] && (k != 0)) begin
        fl_vld = 1'b1;
        fl_idx = IW'(k);
      end
    end
  end

  // Effective flush target merges the new request with any deferred one.
  always_comb begin
    f_vld = fl_vld | pend_vld_q;
    f_idx = fl_idx;
    if (pend_vld_q && (!fl_vld || (pend_idx_q > fl_idx))) begin
      f_idx = pend_idx_q;
    end
  end

  always_comb begin
    stall_raw  = '0;
    bubble_raw = '0;
    flush_raw  = '0;
    issue      = 1'b0;
    defer      = 1'b0;
    if (!rdy) begin
      stall_raw = '1;
    end else if (f_vld && !(s_vld && (s_idx >= f_idx))) begin
      // Flush wins: nothing stalled at or above the redirecting stage.
      issue = 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        flush_raw[k] = (k < int'(f_idx));
      end
    end else begin
      // A stall at or above the flush stage would lose the redirect; hold it instead.
      defer = f_vld;
      for (int k = 0; k < STAGES; k++) begin
        stall_raw[k] = s_vld && (k <= int'(s_idx));
      end
      for (int k = 1; k < STAGES; k++) begin
        bubble_raw[k] = s_vld && (k == int'(s_idx) + 1);
      end
    end
  end

  assign stall_any = rdy && (|stall_raw);

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_idx_d  = pend_idx_q;
    stall_cnt_d = stall_cnt_q;
    run_cnt_d   = run_cnt_q;
    if (rdy) begin
      if (issue) begin
        pend_vld_d = 1'b0;
      end else if (defer) begin
        pend_vld_d = 1'b1;
        pend_idx_d = f_idx;
      end
      if (stall_any) begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (run_cnt_q != RW'(TIMEOUT)) run_cnt_d = run_cnt_q + RW'(1);
      end else begin
        run_cnt_d = '0;
      end
    end
    timeout_d = timeout_q | (run_cnt_d == RW'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
      stall_cnt_q <= '0;
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_idx_q  <= pend_idx_d;
      stall_cnt_q <= stall_cnt_d;
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Combinational outputs are forced quiet while reset is asserted.
  assign stall_o      = rst ? '0 : stall_raw;
  assign bubble_o     = rst ? '0 : bubble_raw;
  assign flush_o      = rst ? '0 : flush_raw;
  assign flush_pend_o = pend_vld_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic [5:0] stall_req_i;
  logic [5:0] flush_req_i;
  logic [5:0] stall_o;
  logic [5:0] bubble_o;
  logic [5:0] flush_o;
  logic       flush_pend_o;
  logic [3:0] stall_cnt_o;
  logic       timeout_o;

  pipe_hazard_ctrl #(.STAGES(6), .CNT_W(4), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall_req_i  (stall_req_i),
    .flush_req_i  (flush_req_i),
    .stall_o      (stall_o),
    .bubble_o     (bubble_o),
    .flush_o      (flush_o),
    .flush_pend_o (flush_pend_o),
    .stall_cnt_o  (stall_cnt_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] stall;
    logic [5:0] bubble;
    logic [5:0] flush;
    logic       pend;
    logic [3:0] cnt;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: pending flush stage (-1 = none), counters, sticky flag.
  int m_pend = -1;
  int m_cnt  = 0;
  int m_run  = 0;
  bit m_tmo  = 1'b0;

  task automatic model_reset();
    m_pend = -1;
    m_cnt  = 0;
    m_run  = 0;
    m_tmo  = 1'b0;
  endtask

  task automatic push_zero(input string nm);
    exp_t e;
    e.name = nm; e.stall = '0; e.bubble = '0; e.flush = '0;
    e.pend = 1'b0; e.cnt = '0; e.tmo = 1'b0;
    sb.push_back(e);
  endtask

  // One clock cycle of stimulus; expected outputs come from the stage-index rules.
  task automatic cycle(input string nm, input logic r, input logic [5:0] s, input logic [5:0] f);
    exp_t e;
    int S, Fl, F;
    @(posedge clk);
    #1;
    rdy = r; stall_req_i = s; flush_req_i = f;
    S = -1;
    for (int k = 0; k < 6; k++) if (s[k]) S = k;
    Fl = -1;
    for (int k = 1; k < 6; k++) if (f[k]) Fl = k;
    F = (Fl > m_pend) ? Fl : m_pend;
    e.name = nm;
    e.pend = (m_pend >= 0);
    e.cnt  = 4'(m_cnt);
    e.tmo  = m_tmo;
    e.stall = '0; e.bubble = '0; e.flush = '0;
    if (!r) begin
      e.stall = 6'h3f;
    end else if (F >= 0 && S < F) begin
      e.flush = 6'((1 << F) - 1);
      m_pend = -1;
    end else begin
      e.stall  = 6'((1 << (S + 1)) - 1);
      e.bubble = (S >= 0 && S < 5) ? 6'(1 << (S + 1)) : 6'd0;
      if (F >= 0) m_pend = F;
    end
    sb.push_back(e);
    if (r) begin
      if (e.stall != 0) begin
        if (m_cnt < 15) m_cnt++;
        if (m_run < 4) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run == 4) m_tmo = 1'b1;
    end
  endtask

  // Assert reset between edges with live requests, then release with idle inputs.
  task automatic reset_mid(input string nm);
    @(posedge clk);
    #1;
    rdy = 1'b1; stall_req_i = 6'b000001; flush_req_i = 6'b000100;
    #2;
    rst = 1'b1;
    push_zero(nm);
    model_reset();
    @(negedge clk);
    #1;
    stall_req_i = '0; flush_req_i = '0;
    rst = 1'b0;
  endtask

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%b expected=%b t=%0t", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "stall",  {2'b0, stall_o},      {2'b0, e.stall});
        chk(e.name, "bubble", {2'b0, bubble_o},     {2'b0, e.bubble});
        chk(e.name, "flush",  {2'b0, flush_o},      {2'b0, e.flush});
        chk(e.name, "pend",   {7'b0, flush_pend_o}, {7'b0, e.pend});
        chk(e.name, "cnt",    {4'b0, stall_cnt_o},  {4'b0, e.cnt});
        chk(e.name, "tmo",    {7'b0, timeout_o},    {7'b0, e.tmo});
      end
    end
  end

  initial begin
    logic [5:0] rs, rf;
    rst = 1'b1; rdy = 1'b1;
    stall_req_i = 6'b010000; flush_req_i = 6'b000100;
    push_zero("reset");
    model_reset();
    @(negedge clk);
    #1;
    stall_req_i = '0; flush_req_i = '0;
    rst = 1'b0;

    // Basic stall decode and counter
    cycle("t1_stall4", 1'b1, 6'b010000, 6'b0);
    cycle("t1_idle",   1'b1, 6'b000000, 6'b0);
    cycle("t2_stall1", 1'b1, 6'b000010, 6'b0);
    cycle("t2_stall5", 1'b1, 6'b100000, 6'b0);
    // Flush overrides a lower stall
    cycle("t3_flush",  1'b1, 6'b000001, 6'b000100);
    cycle("t3_after",  1'b1, 6'b000000, 6'b0);
    // Deferral then release
    cycle("t4_def1",   1'b1, 6'b010000, 6'b000100);
    cycle("t4_def2",   1'b1, 6'b010000, 6'b0);
    cycle("t4_def3",   1'b1, 6'b010000, 6'b0);
    cycle("t4_rel",    1'b1, 6'b000000, 6'b0);
    cycle("t4_post",   1'b1, 6'b000000, 6'b0);
    // Merge: later, higher request while pending
    cycle("t4v_def1",  1'b1, 6'b010000, 6'b000100);
    cycle("t4v_def2",  1'b1, 6'b010000, 6'b010000);
    cycle("t4v_rel",   1'b1, 6'b000000, 6'b0);
    cycle("t4v_post",  1'b1, 6'b000000, 6'b0);
    // Global pause with a pending flush
    cycle("t5_def",    1'b1, 6'b010000, 6'b000100);
    for (int i = 0; i < 3; i++) cycle("t5_pause", 1'b0, 6'b000010, 6'b0);
    cycle("t5_rel",    1'b1, 6'b000000, 6'b0);
    cycle("t5_post",   1'b1, 6'b000000, 6'b0);
    // Watchdog and counter saturation
    for (int i = 0; i < 20; i++) cycle("t6_wd", 1'b1, 6'b000001, 6'b0);
    cycle("t6_idle",   1'b1, 6'b000000, 6'b0);
    cycle("t6_idle2",  1'b1, 6'b000000, 6'b0);
    // Reset during deferral
    cycle("t6_def",    1'b1, 6'b010000, 6'b000100);
    reset_mid("t6_rst");
    cycle("t6_postrst", 1'b1, 6'b000000, 6'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_mid("rnd_rst");
      end else begin
        rs = ($urandom_range(0, 2) == 0) ? 6'($urandom) & 6'($urandom) : 6'd0;
        rf = ($urandom_range(0, 4) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
        cycle("rnd", ($urandom_range(0, 7) != 0), rs, rf);
      end
    end

    // Drain the scoreboard with a bounded wait
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
